// File: rtl/riscv_pkg.sv
// Shared rename-table widths and the per-register entry layout.
package riscv_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int Q_WIDTH        = 4;
  localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;

  typedef struct packed {
    logic [31:0]        value;
    logic               busy;
    logic [Q_WIDTH-1:0] tag;
  } entry_t;

endpackage

// File: rtl/rename_regfile_rdport.sv
// One combinational read port of the rename register file.
// RENAME_REGFILE_BYPASS_EN forwards a tag-matching same-cycle commit to the port.
module rename_regfile_rdport
  import riscv_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = riscv_pkg::REG_ADDR_WIDTH,
  parameter int Q_WIDTH        = riscv_pkg::Q_WIDTH
) (
  input  entry_t                    regs [2**REG_ADDR_WIDTH],
  input  logic [REG_ADDR_WIDTH-1:0] addr,
`ifdef RENAME_REGFILE_BYPASS_EN
  input  logic                      commit_en,
  input  logic [REG_ADDR_WIDTH-1:0] commit_rd,
  input  logic [Q_WIDTH-1:0]        commit_q,
  input  logic [31:0]               commit_v,
`endif
  output logic                      busy,
  output logic [Q_WIDTH-1:0]        q,
  output logic [31:0]               val
);

  // Entry 0 is never written, so it always reads back as zero.
  always_comb begin
    busy = regs[addr].busy;
    q    = regs[addr].tag;
    val  = regs[addr].value;
`ifdef RENAME_REGFILE_BYPASS_EN
    // Forwarding looks only at committed state; a same-cycle rename is invisible here.
    if (commit_en && (addr != '0) && (commit_rd == addr) && (regs[addr].tag == commit_q)) begin
      busy = 1'b0;
      val  = commit_v;
    end
`endif
  end

endmodule

// File: rtl/rename_regfile.sv
// Register-renaming table: architectural value plus busy/ROB-tag per register.
// Build option RENAME_REGFILE_BYPASS_EN enables commit-to-read forwarding on both ports.
module rename_regfile
  import riscv_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = riscv_pkg::REG_ADDR_WIDTH,
  parameter int Q_WIDTH        = riscv_pkg::Q_WIDTH
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      rename_en,
  input  logic [REG_ADDR_WIDTH-1:0] rename_rd,
  input  logic [Q_WIDTH-1:0]        rename_q,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic [Q_WIDTH-1:0]        rs1_q,
  output logic [Q_WIDTH-1:0]        rs2_q,
  output logic [31:0]               rs1_val,
  output logic [31:0]               rs2_val,
  input  logic                      commit_en,
  input  logic [REG_ADDR_WIDTH-1:0] commit_rd,
  input  logic [Q_WIDTH-1:0]        commit_q,
  input  logic [31:0]               commit_v,
  input  logic                      flush_in
);

  localparam int DEPTH = 2 ** REG_ADDR_WIDTH;

  entry_t regs [DEPTH];

  logic do_commit;
  logic do_rename;

  assign do_commit = commit_en && (commit_rd != '0);
  assign do_rename = rename_en && (rename_rd != '0) && !flush_in;

  // Later assignments win: flush clears, commit may clear, rename re-sets busy.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int i = 0; i < DEPTH; i++) begin
          regs[i].busy <= 1'b0;
        end
      end
      if (do_commit) begin
        regs[commit_rd].value <= commit_v;
        if (regs[commit_rd].tag == commit_q) begin
          regs[commit_rd].busy <= 1'b0;
        end
      end
      if (do_rename) begin
        regs[rename_rd].busy <= 1'b1;
        regs[rename_rd].tag  <= rename_q;
      end
    end
  end

  rename_regfile_rdport #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .Q_WIDTH       (Q_WIDTH)
  ) u_rdport1 (
    .regs     (regs),
    .addr     (rs1_addr),
`ifdef RENAME_REGFILE_BYPASS_EN
    .commit_en(commit_en),
    .commit_rd(commit_rd),
    .commit_q (commit_q),
    .commit_v (commit_v),
`endif
    .busy     (rs1_busy),
    .q        (rs1_q),
    .val      (rs1_val)
  );

  rename_regfile_rdport #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .Q_WIDTH       (Q_WIDTH)
  ) u_rdport2 (
    .regs     (regs),
    .addr     (rs2_addr),
`ifdef RENAME_REGFILE_BYPASS_EN
    .commit_en(commit_en),
    .commit_rd(commit_rd),
    .commit_q (commit_q),
    .commit_v (commit_v),
`endif
    .busy     (rs2_busy),
    .q        (rs2_q),
    .val      (rs2_val)
  );

endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: directed scenarios plus randomized traffic
// compared every cycle against a behavioural register-table model.
module tb_rename_regfile;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        rename_en;
  logic [4:0]  rename_rd;
  logic [3:0]  rename_q;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_q, rs2_q;
  logic [31:0] rs1_val, rs2_val;
  logic        commit_en;
  logic [4:0]  commit_rd;
  logic [3:0]  commit_q;
  logic [31:0] commit_v;
  logic        flush_in;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];

  always #5 clk_in = ~clk_in;

  rename_regfile dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .rdy_in   (rdy_in),
    .rename_en(rename_en),
    .rename_rd(rename_rd),
    .rename_q (rename_q),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rs1_q    (rs1_q),
    .rs2_q    (rs2_q),
    .rs1_val  (rs1_val),
    .rs2_val  (rs2_val),
    .commit_en(commit_en),
    .commit_rd(commit_rd),
    .commit_q (commit_q),
    .commit_v (commit_v),
    .flush_in (flush_in)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
  endfunction

  // What a read of register a must return given the table and the current commit inputs.
  function automatic void model_read(input logic [4:0] a, output logic b,
                                     output logic [3:0] q, output logic [31:0] v);
    b = m_busy[a]; q = m_tag[a]; v = m_val[a];
    if (a == 5'd0) begin b = 1'b0; q = '0; v = '0; end
`ifdef RENAME_REGFILE_BYPASS_EN
    if (commit_en && commit_rd == a && a != 5'd0 && m_tag[a] == commit_q) begin
      b = 1'b0; v = commit_v;
    end
`endif
  endfunction

  // Architectural effect of one accepted clock edge.
  function automatic void model_edge();
    if (flush_in)
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    if (commit_en && commit_rd != 5'd0) begin
      m_val[commit_rd] = commit_v;
      if (m_tag[commit_rd] == commit_q) m_busy[commit_rd] = 1'b0;
    end
    if (rename_en && rename_rd != 5'd0 && !flush_in) begin
      m_busy[rename_rd] = 1'b1;
      m_tag[rename_rd]  = rename_q;
    end
  endfunction

  always @(negedge clk_in) begin
    logic b; logic [3:0] q; logic [31:0] v;
    #2;
    if (checking) begin
      model_read(rs1_addr, b, q, v);
      chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, b});
      chk("rs1_q",    {28'd0, rs1_q},    {28'd0, q});
      chk("rs1_val",  rs1_val,           v);
      model_read(rs2_addr, b, q, v);
      chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, b});
      chk("rs2_q",    {28'd0, rs2_q},    {28'd0, q});
      chk("rs2_val",  rs2_val,           v);
    end
  end

  task automatic drive(input logic ren, input logic [4:0] rrd, input logic [3:0] rq,
                       input logic cen, input logic [4:0] crd, input logic [3:0] cq,
                       input logic [31:0] cv, input logic fl, input logic rdy,
                       input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk_in);
    rename_en = ren; rename_rd = rrd; rename_q = rq;
    commit_en = cen; commit_rd = crd; commit_q = cq; commit_v = cv;
    flush_in = fl; rdy_in = rdy; rs1_addr = a1; rs2_addr = a2;
    #3;
  endtask

  task automatic tick();
    @(posedge clk_in);
    if (rst_n_in && rdy_in) model_edge();
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, a1, a2);
  endtask

  task automatic lit1(input string nm, input logic b, input logic [3:0] q, input logic [31:0] v);
    chk({nm, "_busy"}, {31'd0, rs1_busy}, {31'd0, b});
    chk({nm, "_q"},    {28'd0, rs1_q},    {28'd0, q});
    chk({nm, "_val"},  rs1_val,           v);
  endtask

  initial begin
    logic [4:0] crd, a1;
    rst_n_in = 1'b0; rdy_in = 1'b1;
    rename_en = 0; rename_rd = 0; rename_q = 0;
    commit_en = 0; commit_rd = 0; commit_q = 0; commit_v = 0;
    flush_in = 0; rs1_addr = 0; rs2_addr = 0;
    model_clear();
    checking = 1'b1;
    repeat (2) tick();
    @(negedge clk_in); rst_n_in = 1'b1;

    // Reset state
    idle(5, 5); lit1("reset_x5", 0, 0, 0); tick();

    // Rename then commit with matching tag
    drive(1, 5, 3, 0, 0, 0, 0, 0, 1, 5, 5); tick();
    idle(5, 5); lit1("x5_renamed", 1, 3, 0); tick();
    drive(0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 0, 1, 5, 5);
`ifdef RENAME_REGFILE_BYPASS_EN
    lit1("x5_bypass", 0, 3, 32'hDEADBEEF);
`else
    lit1("x5_commit_cycle", 1, 3, 0);
`endif
    tick();
    idle(5, 5); lit1("x5_committed", 0, 3, 32'hDEADBEEF); tick();

    // Older commit must not clear a younger rename
    drive(1, 7, 2, 0, 0, 0, 0, 0, 1, 7, 7); tick();
    drive(1, 7, 4, 0, 0, 0, 0, 0, 1, 7, 7); tick();
    drive(0, 0, 0, 1, 7, 2, 32'h11, 0, 1, 7, 7); tick();
    idle(7, 7); lit1("x7_stale_commit", 1, 4, 32'h11); tick();
    drive(0, 0, 0, 1, 7, 4, 32'h22, 0, 1, 7, 7); tick();
    idle(7, 7); lit1("x7_final_commit", 0, 4, 32'h22); tick();

    // Same-cycle rename and commit
    drive(1, 9, 6, 1, 9, 6, 32'h55, 0, 1, 9, 9); tick();
    idle(9, 9); lit1("x9_rename_commit", 1, 6, 32'h55); tick();

    // Flush drops busy bits and the same-cycle rename
    drive(0, 0, 0, 1, 2, 0, 32'h222, 0, 1, 2, 2); tick();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 2); tick();
    drive(1, 2, 2, 0, 0, 0, 0, 0, 1, 1, 2); tick();
    drive(1, 3, 3, 0, 0, 0, 0, 0, 1, 3, 2); tick();
    drive(1, 4, 5, 0, 0, 0, 0, 1, 1, 1, 4); tick();
    idle(1, 1); lit1("flush_x1", 0, 1, 0); tick();
    idle(2, 2); lit1("flush_x2", 0, 2, 32'h222); tick();
    idle(3, 3); lit1("flush_x3", 0, 3, 0); tick();
    idle(4, 4); lit1("flush_x4", 0, 0, 0); tick();

    // rdy_in low freezes state; x0 ignores writes
    drive(1, 10, 8, 1, 11, 0, 32'h99, 0, 0, 10, 10); tick();
    idle(10, 11);
    lit1("stall_x10", 0, 0, 0);
    chk("stall_x11_val", rs2_val, 32'h0);
    tick();
    drive(1, 0, 7, 1, 0, 0, 32'hFF, 0, 1, 0, 0); tick();
    idle(0, 0); lit1("x0_const", 0, 0, 0); tick();

    // Randomized traffic on a small register window to force collisions
    for (int n = 0; n < 600; n++) begin
      crd = 5'($urandom_range(0, 7));
      a1  = 5'($urandom_range(0, 7));
      drive($urandom % 2, 5'($urandom_range(0, 7)), 4'($urandom),
            ($urandom % 3) != 0, crd, ($urandom % 2) ? m_tag[crd] : 4'($urandom), $urandom,
            ($urandom % 20) == 0, ($urandom % 10) != 0,
            a1, ($urandom % 4 == 0) ? a1 : 5'($urandom_range(0, 7)));
      tick();
    end

    // Reset asserted mid-stream, then immediate rename after release
    idle(7, 5);
    rst_n_in = 1'b0; model_clear();
    #1;
    lit1("midreset_x7", 0, 0, 0);
    tick();
    drive(1, 5, 9, 0, 0, 0, 0, 0, 1, 5, 5);
    rst_n_in = 1'b1;
    tick();
    idle(5, 5); lit1("post_reset_rename", 1, 9, 0); tick();

    idle(0, 0); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rename_regfile.md
RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 Parameters SHALL be:
- REG_ADDR_WIDTH, default 5, architectural register index width.
- Q_WIDTH, default 4, ROB tag width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_in, input, 1: the single clock.
- rst_n_in, input, 1: asynchronous active-low reset.
- rdy_in, input, 1: global enable; low freezes all state.
- rename_en, input, 1: issue allocates ROB entry writing rename_rd.
- rename_rd, input, REG_ADDR_WIDTH: destination register of issued instruction.
- rename_q, input, Q_WIDTH: ROB tail tag assigned to that instruction.
- rs1_addr, rs2_addr, input, REG_ADDR_WIDTH: issue-stage source indices.
- rs1_busy, rs2_busy, output, 1: source awaits ROB result.
- rs1_q, rs2_q, output, Q_WIDTH: producing ROB tag, valid when busy.
- rs1_val, rs2_val, output, 32: architectural value, valid when not busy.
- commit_en, input, 1: ROB commits a register write.
- commit_rd, input, REG_ADDR_WIDTH: committed destination.
- commit_q, input, Q_WIDTH: ROB head tag of committed entry.
- commit_v, input, 32: committed value.
- flush_in, input, 1: control hazard from ROB commit; squash all renames.

Function
REQ-003 State SHALL be 2**REG_ADDR_WIDTH entries of {value[31:0], busy, tag[Q_WIDTH-1:0]}.
REQ-004 All state updates SHALL occur on posedge clk_in only when rdy_in=1; rdy_in=0 holds every entry unchanged.
REQ-005 Register 0 SHALL read value 0, busy 0, tag 0 always; renames and commits to index 0 SHALL be ignored.
REQ-006 Commit (commit_en=1, commit_rd!=0) SHALL write commit_v into value[commit_rd] next edge, unconditionally.
REQ-007 Commit SHALL clear busy[commit_rd] only if tag[commit_rd]==commit_q; otherwise busy and tag are kept (younger rename outstanding).
REQ-008 Rename (rename_en=1, rename_rd!=0, flush_in=0) SHALL set busy[rename_rd]=1 and tag[rename_rd]=rename_q next edge.
REQ-009 Simultaneous rename and commit to the same register SHALL leave busy=1 and tag=rename_q, with value=commit_v.
REQ-010 flush_in=1 SHALL clear every busy bit next edge, keep all values and tags, drop any same-cycle rename, and still perform any same-cycle commit value write.
REQ-011 Read ports SHALL be combinational with zero-cycle latency; rsN_q SHALL equal stored tag[rsN_addr] regardless of busy.
REQ-012 Both read ports SHALL be independent; same address on both gives identical outputs.

Reset
REQ-013 rst_n_in low SHALL immediately and asynchronously set every value, busy bit and tag to 0; all outputs then read busy=0, q=0, val=0.
REQ-014 Reset deassertion mid-stream SHALL leave the block accepting rename/commit on the first subsequent edge with rdy_in=1.

Configuration
REQ-015 Macro RENAME_REGFILE_BYPASS_EN SHALL control commit-to-read forwarding.
- Defined: if commit_en=1, commit_rd==rsN_addr!=0 and tag matches commit_q, the port SHALL output busy=0 and val=commit_v in the same cycle.
- Undefined: ports reflect registered state only; the change appears one cycle after commit.
REQ-016 Bypass SHALL NOT consider same-cycle rename; the read always returns pre-rename state.

Structure
REQ-017 Shared package riscv_pkg SHALL hold REG_ADDR_WIDTH, Q_WIDTH, NUM_REGS and the entry struct typedef {value, busy, tag}.
REQ-018 Sub-module rename_regfile_rdport SHALL implement one read port including optional bypass, instantiated twice.

Verification
REQ-019 Reset, then read rs1=5 -> busy=0, q=0, val=0.
REQ-020 Rename x5 q=3, then commit x5 q=3 v=0xDEADBEEF -> cycle after rename busy=1 q=3; cycle after commit busy=0 val=0xDEADBEEF; with bypass, busy=0 val=0xDEADBEEF in the commit cycle.
REQ-021 Rename x7 q=2, rename x7 q=4, commit x7 q=2 v=0x11 -> val=0x11, busy=1, q=4; commit x7 q=4 v=0x22 -> busy=0, val=0x22.
REQ-022 Rename x9 q=6 plus commit x9 q=6 v=0x55 same cycle -> busy=1, q=6, val=0x55.
REQ-023 Rename x1,x2,x3 with q=1,2,3, then flush_in=1 with rename x4 q=5 -> next cycle busy=0 for x1..x4, prior values unchanged.
REQ-024 rdy_in=0 during rename x10 q=8 and commit x11 v=0x99 -> no change; rename/commit to x0 -> x0 stays val=0, busy=0.
